// File: rtl/seg_display_mux_if.sv
// Display-driver bus: datapath-side digit inputs and pin-side outputs.
// The driver sits on the slave modport; whoever feeds it holds master.
interface seg_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blink_en;
  logic                  blank_lz;
  logic [3:0]            brightness;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_start;

  modport master (
    output value, dp_in, blink_en, blank_lz, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  value, dp_in, blink_en, blank_lz, brightness,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed 7-segment driver: self-timed digit scan, hex decode, leading-zero
// blanking, per-digit blink and 16-step PWM, inputs sampled once per frame.
module seg_display_mux #(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 250000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_display_mux_if.slave bus
);
  localparam int   STEP = CLK_DIV / 16;
  localparam int   PW   = $clog2(CLK_DIV);
  localparam int   SW   = $clog2(STEP);
  localparam int   DW   = $clog2(N_DIGITS);
  localparam int   FW   = $clog2(BLINK_FRAMES + 1);
  localparam logic POL  = (ACTIVE_LOW != 0);

  logic [PW-1:0]         r_pre;
  logic [SW-1:0]         r_stp;
  logic [3:0]            r_phase;
  logic [DW-1:0]         r_dig;
  logic [FW-1:0]         r_fcnt;
  logic                  r_blink, r_valid, r_fs;
  logic [4*N_DIGITS-1:0] r_val;
  logic [N_DIGITS-1:0]   r_dp, r_blk;
  logic                  r_lz;
  logic [3:0]            r_bri;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dpo;

  logic                  w_slot_tick, w_frame, w_lz, w_dark;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_upper_nz, w_onehot;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_slot_tick = (r_pre == PW'(CLK_DIV - 1));
  assign w_frame     = w_slot_tick && (r_dig == DW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_stp   <= '0;
      r_phase <= '0;
      r_dig   <= '0;
    end else begin
      r_pre <= w_slot_tick ? '0 : r_pre + 1'b1;
      if (w_slot_tick) begin
        r_stp   <= '0;
        r_phase <= '0;
      end else if (r_stp == SW'(STEP - 1)) begin
        r_stp   <= '0;
        r_phase <= r_phase + 1'b1;
      end else begin
        r_stp <= r_stp + 1'b1;
      end
      if (w_slot_tick)
        r_dig <= (r_dig == DW'(N_DIGITS - 1)) ? '0 : r_dig + 1'b1;
    end
  end

  // The capture that first sets valid opens frame 0, so blink counting only
  // starts on the boundaries after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_dp    <= '0;
      r_blk   <= '0;
      r_lz    <= 1'b0;
      r_bri   <= '0;
      r_valid <= 1'b0;
      r_fcnt  <= '0;
      r_blink <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_fs <= w_frame;
      if (w_frame) begin
        r_val   <= bus.value;
        r_dp    <= bus.dp_in;
        r_blk   <= bus.blink_en;
        r_lz    <= bus.blank_lz;
        r_bri   <= bus.brightness;
        r_valid <= 1'b1;
        if (r_valid) begin
          if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
            r_fcnt  <= '0;
            r_blink <= ~r_blink;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_nz
    assign w_upper_nz[i] = |r_val[4*N_DIGITS-1:4*i];
  end

  always_comb begin
    w_nib            = r_val[4*r_dig +: 4];
    w_onehot         = '0;
    w_onehot[r_dig]  = 1'b1;
    w_lz             = r_lz && (r_dig != '0) && !w_upper_nz[r_dig];
    // brightness <= phase keeps at least the last sub-phase dark for anti-ghosting
    w_dark           = !r_valid || (r_bri <= r_phase) || (r_blk[r_dig] && r_blink) || w_lz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= {N_DIGITS{POL}};
      r_seg <= {7{POL}};
      r_dpo <= POL;
    end else begin
      r_an  <= (w_dark ? '0 : w_onehot) ^ {N_DIGITS{POL}};
      r_seg <= (w_dark ? 7'h00 : hex7(w_nib)) ^ {7{POL}};
      r_dpo <= (!w_dark && r_dp[r_dig]) ^ POL;
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dpo;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_seg_display_mux.sv
// Frame-level scoreboard bench for seg_display_mux: expected per-slot views are
// queued when a frame's inputs are driven and compared as each slot is displayed.
module tb_seg_display_mux;
  localparam int N = 4, CD = 32, BF = 2, AL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_mux_if #(.N_DIGITS(N)) bus ();
  seg_display_mux #(.N_DIGITS(N), .CLK_DIV(CD), .BLINK_FRAMES(BF), .ACTIVE_LOW(AL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [5:0] lit;
    logic [5:0] lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       bad;
  } obs_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blk;
    logic        lz;
    logic [3:0]  bri;
    int          dly;
  } row_t;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  obs_t exp_q[$];
  row_t cur[8];
  int   errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input row_t r);
    bus.value      = r.val;
    bus.dp_in      = r.dp;
    bus.blink_en   = r.blk;
    bus.blank_lz   = r.lz;
    bus.brightness = r.bri;
  endtask

  task automatic push_frame(input row_t r, input int fidx);
    logic bph, upz, dark;
    obs_t o;
    bph = ((fidx / BF) % 2) == 1;
    for (int d = 0; d < N; d++) begin
      upz = 1'b1;
      for (int k = d; k < N; k++) if (r.val[4*k +: 4] != 4'h0) upz = 1'b0;
      dark = (r.bri == 4'd0) || (r.blk[d] && bph) || (r.lz && d > 0 && upz);
      if (dark) o = '{lit: 6'd0, lead: 6'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1, bad: 1'b0};
      else o = '{lit: 6'(2*r.bri), lead: 6'(2*r.bri), an: ~(4'b0001 << d),
                 seg: ~hex_tbl[r.val[4*d +: 4]], dp: ~r.dp[d], bad: 1'b0};
      exp_q.push_back(o);
    end
  endtask

  task automatic run_seq(input string name);
    int   cyc, fs_cnt, fs_at;
    logic lit_bad, darkseen;
    obs_t o, e;
    apply(cur[0]);
    push_frame(cur[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    lit_bad = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) lit_bad = 1'b1;
      if (bus.frame_start === 1'b1) break;
    end
    chk({name, "_first_fs"}, cyc, 128);
    chk({name, "_first_dark"}, {31'd0, lit_bad}, 0);
    for (int f = 0; f < 8; f++) begin
      fs_cnt = 0;
      fs_at  = -1;
      for (int s = 0; s < N; s++) begin
        o = '{lit: 6'd0, lead: 6'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1, bad: 1'b0};
        darkseen = 1'b0;
        for (int c = 0; c < CD; c++) begin
          @(negedge clk);
          if (f < 7 && s*CD + c == cur[f+1].dly) begin
            apply(cur[f+1]);
            push_frame(cur[f+1], f + 1);
          end
          if (bus.frame_start === 1'b1) begin
            fs_cnt++;
            fs_at = s*CD + c;
          end
          if (bus.an !== 4'hF) begin
            if (o.lit != 0 && (bus.an !== o.an || bus.seg !== o.seg || bus.dp !== o.dp))
              o.bad = 1'b1;
            o.lit++;
            if (!darkseen) o.lead++;
            o.an  = bus.an;
            o.seg = bus.seg;
            o.dp  = bus.dp;
          end else begin
            darkseen = 1'b1;
            if (bus.seg !== 7'h7F || bus.dp !== 1'b1) o.bad = 1'b1;
          end
        end
        if (exp_q.size() == 0) begin
          chk($sformatf("%s_f%0d_d%0d_underrun", name, f, s), 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s_f%0d_d%0d", name, f, s), {7'd0, o}, {7'd0, e});
        end
      end
      chk($sformatf("%s_f%0d_fs", name, f), {fs_cnt[15:0], fs_at[15:0]}, {16'd1, 16'd127});
    end
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    cur[0] = '{16'h0000, 4'h0, 4'h0, 1'b0, 4'd0, 0};
    apply(cur[0]);
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, bus.an}, 4'hF);
    chk("rst_seg", {25'd0, bus.seg}, 7'h7F);
    chk("rst_dp_fs", {30'd0, bus.dp, bus.frame_start}, 2'b10);

    // decode, PWM levels, leading-zero blanking, decimal point, mid-frame input change
    cur[0] = '{16'h12AF, 4'h0,    4'h0, 1'b0, 4'd15, 0};
    cur[1] = '{16'h12AF, 4'h0,    4'h0, 1'b0, 4'd8,  0};
    cur[2] = '{16'h12AF, 4'h0,    4'h0, 1'b0, 4'd0,  0};
    cur[3] = '{16'h0005, 4'h0,    4'h0, 1'b1, 4'd15, 0};
    cur[4] = '{16'h0000, 4'h0,    4'h0, 1'b1, 4'd15, 0};
    cur[5] = '{16'h0500, 4'h0,    4'h0, 1'b1, 4'd15, 0};
    cur[6] = '{16'h1234, 4'b0100, 4'h0, 1'b0, 4'd15, 0};
    cur[7] = '{16'h9876, 4'h0,    4'h0, 1'b0, 4'd15, 40};
    run_seq("A");

    // asynchronous reset while digit 0 is lit
    repeat (5) @(negedge clk);
    chk("pre_rst_an", {28'd0, bus.an}, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {28'd0, bus.an}, 4'hF);
    chk("async_rst_seg_dp", {24'd0, bus.seg, bus.dp}, {7'h7F, 1'b1});
    repeat (2) @(negedge clk);

    // blink on digit 1: dark in frames 2,3,6,7 counted from the first frame_start
    for (int k = 0; k < 8; k++)
      cur[k] = '{16'hAB60 | 16'(k), 4'b0001, 4'b0010, 1'b0, 4'd15, 0};
    run_seq("B");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
